pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Four-channel PWM scheduler and duty-slew controller. It owns the shared 8-bit period counter and accepts duty commands from a host over a valid/ready interface. Each channel's active duty changes only at a period boundary; with ramping compiled in, it slews toward the commanded target by a fixed step per period. It sits between the host register bank and the PWM output pins and replaces per-channel free-running generators with one sequenced, glitch-free datapath.

## Interface
- `NCH`, default 4: number of channels, range 1..8.
- `STEP`, default 1: duty slew per period, unsigned, range 1..255; used only with `PWM_RAMP_EN`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  run enable. When low, the counter holds at 0 and all `pwm_out` bits are 0.
- `cmd_valid`  in  1  command strobe.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_chan`  in  3  target channel. Values ≥ NCH are accepted and discarded.
- `cmd_duty`  in  8  target duty, unsigned, 0..255.
- `pwm_out`  out  NCH  PWM outputs.
- `period_end`  out  1  1-cycle pulse in the cycle where the counter is 255 and `en` is 1.
- `busy`  out  1  high while any channel's current duty differs from its target duty.

## Operation
- Reset (`rst_n` low at a `clk` edge) sets:
  - counter = 0, `cur[i]` = 0, `tgt[i]` = 0;
  - `cmd_ready` = 0, `pwm_out` = 0, `period_end` = 0, `busy` = 0.
- `cmd_ready` is a register. It goes to 1 on the first edge after `rst_n` is sampled high and stays 1 until the next reset. `en` does not affect it.
- Counter: unsigned 8-bit. It increments by 1 when `en` is 1 and wraps 255→0. When `en` is 0 it is reset to 0.
- `pwm_out[i]` = (counter < `cur[i]`), unsigned compare, decoded combinationally from registers and gated by `en`.
  - Duty 0 gives constant low.
  - Duty 255 gives high for 255 of every 256 cycles.
- An accepted command writes `tgt[cmd_chan]` = `cmd_duty` on the same edge. The last write wins and there is no queue.
- Boundary update happens on the edge where counter = 255 and `en` = 1. `cur[i]` changes only on this edge, so the new duty applies from counter = 0.
- Per-channel state machine, re-evaluated on every boundary:
  - IDLE (`cur` == `tgt`): no change.
  - UP (`cur` < `tgt`): `cur` ← min(`cur` + STEP, `tgt`). Computed in 9 bits, so it never wraps.
  - DN (`cur` > `tgt`): `cur` ← max(`cur` − STEP, `tgt`). Computed as signed 9-bit, so it never underflows.
  - The state follows `tgt` immediately on a command write. A command can move a channel from UP to DN in mid-ramp.
- Simultaneous command and boundary on the same edge: the boundary step uses the old `tgt`. The new `tgt` takes effect from the next boundary.
- `busy` = OR over i of (`cur[i]` != `tgt[i]`), registered. It reflects state after the edge.
- `en` deassert mid-period:
  - the counter returns to 0 and `cur`/`tgt` are held;
  - re-assert starts a full period from 0.
- Reset mid-ramp discards all targets and duties.

## Timing
- Command to `tgt` update: 1 edge.
- Command to visible output change: at the next counter 255→0 transition, up to 256 cycles.
- Ramp from `cur` to `tgt` takes ceil(|`tgt` − `cur`| / STEP) periods.
- `period_end` is asserted combinationally in the counter = 255 cycle.
- There is no combinational path from `cmd_*` to any output.

## Configuration
- `PWM_RAMP_EN` defined: slew behaviour as described above. STEP is honoured and `busy` may stay high for many periods.
- `PWM_RAMP_EN` undefined: at each boundary `cur[i]` ← `tgt[i]` directly. STEP is ignored. `busy` is high only from a command until the next boundary.

## Test plan
- Reset with `en` = 1, then no commands for 512 cycles → `pwm_out` = 0 throughout, `period_end` pulses every 256 cycles, and `cmd_ready` = 1 from the second cycle after reset release.
- Ramp up: `PWM_RAMP_EN`, STEP = 16, write ch0 = 100 → ch0 high-time per period is 0, then 16, 32, 48, 64, 80, 96, 100, then stable at 100. `busy` falls at the boundary that applies 100.
- Ramp reversal: ch1 ramping 0→200 at STEP = 16; at `cur` = 48, write 20 → next periods apply 32, then 20. Applied duty is never below 20 and never wraps.
- Simultaneous: write ch2 = 255 on the counter = 255 edge with `tgt` = 0 → ch2 stays 0 for that period and starts ramping one boundary later. Macro off: 255 applies one period later.
- Extremes with macro off: ch3 = 255 → exactly 255 high cycles per 256. ch3 = 0 → constant low. `cmd_chan` = 5 with NCH = 4 → no channel changes.
- Enable and reset mid-operation: drop `en` at counter = 130 → all outputs 0 and counter = 0; re-assert → full 256-cycle period with the prior duties. Assert `rst_n` = 0 mid-ramp → all `cur`/`tgt` = 0 on the next edge.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Four-channel PWM scheduler with a shared 8-bit period counter and per-channel duty slew.
// Define PWM_RAMP_EN to slew duty by STEP per period; otherwise duty jumps to target at the boundary.
module pwm_ramp_ctrl #(
    parameter int NCH  = 4,
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_chan,
    input  logic [7:0]     cmd_duty,
    output logic [NCH-1:0] pwm_out,
    output logic           period_end,
    output logic           busy
);

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_UP,
        CH_DN
    } ch_state_t;

    if (NCH < 1 || NCH > 8 || STEP < 1 || STEP > 255) begin : g_bad_cfg
        $error("pwm_ramp_ctrl: NCH must be 1..8 and STEP 1..255");
    end

`ifdef PWM_RAMP_EN
    localparam logic [7:0] STEP8 = 8'(STEP);
`endif

    logic [7:0] counter;
    logic [7:0] cur     [NCH];
    logic [7:0] tgt     [NCH];
    logic [7:0] cur_nxt [NCH];
    logic [7:0] tgt_nxt [NCH];
    ch_state_t  ch_state [NCH];
    logic       boundary;
    logic       cmd_fire;
    logic       busy_nxt;

    always_comb begin
        boundary   = en && (counter == 8'hFF);
        period_end = boundary;
        cmd_fire   = cmd_valid && cmd_ready;
    end

    // Channel state is a pure function of cur/tgt, so it tracks a new target immediately.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_state[i] = CH_IDLE;
            if (cur[i] < tgt[i])
                ch_state[i] = CH_UP;
            else if (cur[i] > tgt[i])
                ch_state[i] = CH_DN;
        end
    end

    always_comb begin
        busy_nxt = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cur_nxt[i] = cur[i];
            tgt_nxt[i] = tgt[i];
            if (boundary) begin
`ifdef PWM_RAMP_EN
                // Clamp on the remaining distance so the step never overshoots or wraps.
                case (ch_state[i])
                    CH_UP:   cur_nxt[i] = ((tgt[i] - cur[i]) <= STEP8) ? tgt[i] : cur[i] + STEP8;
                    CH_DN:   cur_nxt[i] = ((cur[i] - tgt[i]) <= STEP8) ? tgt[i] : cur[i] - STEP8;
                    default: cur_nxt[i] = cur[i];
                endcase
`else
                if (ch_state[i] != CH_IDLE)
                    cur_nxt[i] = tgt[i];
`endif
            end
            // The boundary step above used the pre-command target.
            if (cmd_fire && (cmd_chan == 3'(i)))
                tgt_nxt[i] = cmd_duty;
            busy_nxt = busy_nxt | (cur_nxt[i] != tgt_nxt[i]);
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int unsigned i = 0; i < NCH; i++)
            pwm_out[i] = en && (counter < cur[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cur[i] <= '0;
                tgt[i] <= '0;
            end
        end else begin
            counter   <= en ? counter + 8'd1 : '0;
            cmd_ready <= 1'b1;
            busy      <= busy_nxt;
            for (int unsigned i = 0; i < NCH; i++) begin
                cur[i] <= cur_nxt[i];
                tgt[i] <= tgt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized self-checking bench for pwm_ramp_ctrl against a period-level behavioural model.
// Builds with or without PWM_RAMP_EN; literal expectations follow the selected mode.
module tb_pwm_ramp_ctrl;

    localparam int NCH  = 4;
    localparam int STEP = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_chan = '0;
    logic [7:0]     cmd_duty = '0;
    logic [NCH-1:0] pwm_out;
    logic           period_end;
    logic           busy;

    pwm_ramp_ctrl #(.NCH(NCH), .STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_duty   (cmd_duty),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model: position in period, applied duty and target per channel.
    int m_cnt = 0;
    int m_cur [NCH];
    int m_tgt [NCH];
    bit m_rdy = 1'b0;
    bit m_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        if (!rst_n) begin
            m_cnt = 0; m_rdy = 1'b0; m_busy = 1'b0;
            for (int i = 0; i < NCH; i++) begin m_cur[i] = 0; m_tgt[i] = 0; end
            return;
        end
        if (en && m_cnt == 255) begin
            for (int i = 0; i < NCH; i++) begin
`ifdef PWM_RAMP_EN
                if (m_tgt[i] > m_cur[i])
                    m_cur[i] = (m_cur[i] + STEP > m_tgt[i]) ? m_tgt[i] : m_cur[i] + STEP;
                else if (m_tgt[i] < m_cur[i])
                    m_cur[i] = (m_cur[i] - STEP < m_tgt[i]) ? m_tgt[i] : m_cur[i] - STEP;
`else
                m_cur[i] = m_tgt[i];
`endif
            end
        end
        if (cmd_valid && m_rdy && int'(cmd_chan) < NCH)
            m_tgt[int'(cmd_chan)] = int'(cmd_duty);
        m_cnt = en ? (m_cnt + 1) % 256 : 0;
        m_rdy = 1'b1;
        m_busy = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (m_cur[i] != m_tgt[i]) m_busy = 1'b1;
    endfunction

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [NCH-1:0] exp_pwm;
            exp_pwm = '0;
            for (int i = 0; i < NCH; i++)
                exp_pwm[i] = en && (m_cnt < m_cur[i]);
            chk("pwm_out", int'(pwm_out), int'(exp_pwm));
            chk("period_end", int'(period_end), int'(en && m_cnt == 255));
            chk("cmd_ready", int'(cmd_ready), int'(m_rdy));
            chk("busy", int'(busy), int'(m_busy));
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input int ch, input int duty);
        cmd_valid = 1'b1;
        cmd_chan  = 3'(ch);
        cmd_duty  = 8'(duty);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic run_to(input int c);
        for (int k = 0; k < 300 && m_cnt != c; k++) cycle();
        chk("run_to_timeout", m_cnt, c);
    endtask

    // High cycles of one channel over the next full period starting at counter 0.
    task automatic measure(input int ch, output int hi);
        run_to(0);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            hi += int'(pwm_out[ch]);
            cycle();
        end
    endtask

    initial begin
        int hi;
        int npe;
        int first_pe;

        // Reset with en high, then an idle stretch.
        rst_n = 1'b0; en = 1'b1;
        cycle(); cycle();
        chk_on = 1'b1;
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        rst_n = 1'b1;
        chk("ready_before_edge", int'(cmd_ready), 0);
        cycle();
        chk("ready_after_edge", int'(cmd_ready), 1);
        npe = 0; hi = 0;
        for (int k = 0; k < 512; k++) begin
            npe += int'(period_end);
            hi  += int'(pwm_out != '0);
            cycle();
        end
        chk("idle_period_end_count", npe, 2);
        chk("idle_pwm_high", hi, 0);

`ifdef PWM_RAMP_EN
        begin
            int exp_up [8] = '{16, 32, 48, 64, 80, 96, 100, 100};
            int exp_rv [5] = '{16, 32, 32, 20, 20};
            send(0, 100);
            for (int p = 0; p < 8; p++) begin
                measure(0, hi);
                chk($sformatf("ramp_up_p%0d", p), hi, exp_up[p]);
                if (p == 6) chk("ramp_up_busy_done", int'(busy), 0);
            end
            send(1, 200);
            for (int p = 0; p < 5; p++) begin
                if (p == 2) send(1, 20);
                measure(1, hi);
                chk($sformatf("reversal_p%0d", p), hi, exp_rv[p]);
            end
        end
`else
        send(1, 200);
        measure(1, hi);
        chk("jump_200", hi, 200);
        send(1, 20);
        measure(1, hi);
        chk("jump_20", hi, 20);
        send(3, 255);
        chk("busy_after_cmd", int'(busy), 1);
        measure(3, hi);
        chk("ch3_255", hi, 255);
        chk("busy_after_boundary", int'(busy), 0);
        send(3, 0);
        measure(3, hi);
        chk("ch3_0", hi, 0);
        send(5, 77);
        chk("discard_busy", int'(busy), 0);
        measure(1, hi);
        chk("discard_ch1", hi, 20);
`endif

        // Command landing on the boundary edge uses the old target for that boundary.
        run_to(255);
        cmd_valid = 1'b1; cmd_chan = 3'd2; cmd_duty = 8'd255;
        cycle();
        cmd_valid = 1'b0;
        measure(2, hi);
        chk("simul_first", hi, 0);
        measure(2, hi);
`ifdef PWM_RAMP_EN
        chk("simul_second", hi, 16);
`else
        chk("simul_second", hi, 255);
`endif

        // Enable drop mid-period, then a full period from zero.
        run_to(130);
        en = 1'b0;
        cycle();
        chk("en_low_pwm", int'(pwm_out), 0);
        chk("en_low_pe", int'(period_end), 0);
        repeat (10) cycle();
        en = 1'b1;
        first_pe = -1;
        for (int k = 0; k < 300 && first_pe < 0; k++) begin
            if (period_end) first_pe = k;
            else cycle();
        end
        chk("reenable_period_len", first_pe, 255);

        // Reset mid-ramp clears all duties and targets.
        send(0, 250);
        measure(0, hi);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_pwm", int'(pwm_out), 0);
        measure(0, hi);
        chk("midreset_ch0", hi, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 6000; k++) begin
            en        = ($urandom_range(0, 1999) != 0);
            rst_n     = ($urandom_range(0, 2999) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_chan  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       cmd_duty = 8'd0;
                1:       cmd_duty = 8'd255;
                default: cmd_duty = 8'($urandom_range(0, 255));
            endcase
            cycle();
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        cycle();
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
